// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the clock period meter.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARM     = 2'b01,
        S_MEAS    = 2'b10,
        S_TIMEOUT = 2'b11
    } meter_state_t;

    localparam int DEFAULT_CNT_W = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/clk_period_meter_edge_sync.sv
// Synchronizer, optional 3-tap majority glitch filter (CLK_METER_FILTER_EN) and
// delay flop producing the level and single-cycle rise/fall pulses of sig_in.
module edge_sync
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 32'sd2) begin : g_bad_stages
        $error("edge_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic                   filt_s;
    logic                   dly_r;

    // Synchronizer chain; only sync_r[0] samples the asynchronous input.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign synced_s = sync_r[SYNC_STAGES-1];

`ifdef CLK_METER_FILTER_EN
    logic [1:0] tap_r;
    logic       flt_r;

    // Majority of three consecutive synced samples; a lone 1-cycle pulse never wins.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tap_r <= 2'b00;
            flt_r <= 1'b0;
        end else begin
            tap_r <= {tap_r[0], synced_s};
            flt_r <= maj3(synced_s, tap_r[0], tap_r[1]);
        end
    end

    assign filt_s = flt_r;
`else
    assign filt_s = synced_s;
`endif

    // Previous-cycle copy of the (filtered) level for edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            dly_r <= 1'b0;
        end else begin
            dly_r <= filt_s;
        end
    end

    assign level = filt_s;
    assign rise  = filt_s & ~dly_r;
    assign fall  = ~filt_s & dly_r;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in clk_in cycles, with loss-of-signal
// timeout. Optional input glitch filter is enabled by defining CLK_METER_FILTER_EN.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic [1:0]       state_out
);

    if (((TIMEOUT >> CNT_W) != 32'sd0) || (TIMEOUT < 32'sd1)) begin : g_bad_timeout
        $error("clk_period_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // ARM starts counting at 0, MEAS at 1 on the rise edge; both thresholds
    // therefore fire TIMEOUT cycles after their reference point.
    localparam logic [CNT_W-1:0] LIM_ARM  = CNT_W'(TIMEOUT - 32'sd1);
    localparam logic [CNT_W-1:0] LIM_MEAS = CNT_W'(TIMEOUT);

    logic         level_s;
    logic         rise_s;
    logic         fall_unused_s;

    meter_state_t     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .sig_in (sig_in),
        .level  (level_s),
        .rise   (rise_s),
        .fall   (fall_unused_s)
    );

    // Measurement FSM, counters and output registers; reset > enable > rise > timeout.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            period_out <= CNT_ZERO;
            high_out   <= CNT_ZERO;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else if (!enable) begin
            state_r    <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    state_r <= S_ARM;
                    cnt_r   <= CNT_ZERO;
                    hcnt_r  <= CNT_ZERO;
                    timeout <= 1'b0;
                end
                S_ARM: begin
                    if (rise_s) begin
                        state_r <= S_MEAS;
                        cnt_r   <= CNT_ONE;
                        hcnt_r  <= CNT_ONE;
                    end else if (cnt_r == LIM_ARM) begin
                        state_r <= S_TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_MEAS: begin
                    if (rise_s) begin
                        period_out <= cnt_r;
                        high_out   <= hcnt_r;
                        meas_valid <= 1'b1;
                        cnt_r      <= CNT_ONE;
                        hcnt_r     <= CNT_ONE;
                    end else if (cnt_r == LIM_MEAS) begin
                        state_r <= S_TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        hcnt_r <= hcnt_r + {{(CNT_W-1){1'b0}}, level_s};
                    end
                end
                S_TIMEOUT: begin
                    if (rise_s) begin
                        state_r <= S_MEAS;
                        cnt_r   <= CNT_ONE;
                        hcnt_r  <= CNT_ONE;
                        timeout <= 1'b0;
                    end else begin
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= CNT_ZERO;
                    hcnt_r  <= CNT_ZERO;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = state_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter against an event-level reference model.
module tb_clk_period_meter;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 100;
    localparam int SYNC_STAGES = 2;
    localparam int NCYC        = 60000;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             timeout;
    logic [1:0]       state_out;

    int total = 0;
    int bad   = 0;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .sig_in     (sig_in),
        .enable     (enable),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .state_out  (state_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    bit samp [0:NCYC-1];
    bit lvl  [0:NCYC-1];
    int k     = 0;
    int clr_k = -1;
    int mode  = 0;       // 0 idle, 1 armed, 2 measuring, 3 lost signal
    int ref_k = 0;       // edge index of the arm point or of the last counted rise
    int exp_period = 0;
    int exp_high   = 0;
    bit m_lv, m_rs;

    typedef struct packed {
        int period;
        int high;
    } meas_t;
    meas_t sbq [$];

    function automatic bit sample_at(input int j);
        if (j < 0 || j <= clr_k || j >= NCYC) return 1'b0;
        return samp[j];
    endfunction

    // Level the meter acts on at edge j: the sample taken SYNC_STAGES edges earlier.
    function automatic bit level_at(input int j);
`ifdef CLK_METER_FILTER_EN
        int ones;
        ones = int'(sample_at(j - SYNC_STAGES - 1)) + int'(sample_at(j - SYNC_STAGES - 2))
             + int'(sample_at(j - SYNC_STAGES - 3));
        return (ones >= 2);
`else
        return sample_at(j - SYNC_STAGES);
`endif
    endfunction

    function automatic int high_sum(input int a, input int b);
        int s = 0;
        for (int j = a; j < b; j++) s += int'(lvl[j]);
        return s;
    endfunction

    // Model update at every active edge, from the same inputs the DUT samples.
    always @(posedge clk_in) begin
        if (k < NCYC) samp[k] = sig_in;
        m_lv = level_at(k);
        m_rs = m_lv & ~level_at(k - 1);
        if (k < NCYC) lvl[k] = m_lv;
        if (reset) begin
            clr_k      = k;
            mode       = 0;
            exp_period = 0;
            exp_high   = 0;
        end else if (!enable) begin
            mode = 0;
        end else begin
            case (mode)
                0: begin
                    mode  = 1;
                    ref_k = k;
                end
                2: begin
                    if (m_rs) begin
                        exp_period = k - ref_k;
                        exp_high   = high_sum(ref_k, k);
                        sbq.push_back('{period: exp_period, high: exp_high});
                        ref_k = k;
                    end else if (k - ref_k == TIMEOUT) begin
                        mode = 3;
                    end
                end
                default: begin
                    if (m_rs) begin
                        mode  = 2;
                        ref_k = k;
                    end else if (mode == 1 && k - ref_k == TIMEOUT) begin
                        mode = 3;
                    end
                end
            endcase
        end
        k++;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
        end
    endtask

    meas_t got_m;

    // Monitor: compare every output half a cycle after each edge; pop on meas_valid.
    always @(negedge clk_in) begin
        chk("state_out", 32'(state_out), 32'(mode));
        chk("timeout", 32'(timeout), 32'(mode == 3));
        chk("period_out", 32'(period_out), 32'(exp_period));
        chk("high_out", 32'(high_out), 32'(exp_high));
        chk("meas_valid", 32'(meas_valid), 32'(sbq.size() != 0));
        if (sbq.size() != 0) begin
            got_m = sbq.pop_front();
            if (meas_valid === 1'b1) begin
                chk("sb_period", 32'(period_out), 32'(got_m.period));
                chk("sb_high", 32'(high_out), 32'(got_m.high));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk_in);
            sig_in = v;
        end
    endtask

    task automatic wave(input int period, input int high, input int count);
        repeat (count) begin
            drive(1'b1, high);
            drive(1'b0, period - high);
        end
    endtask

    initial begin
        int p, h, n;
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        reset  = 1'b0;
        enable = 1'b1;

        // steady divider output, period 20 / high 10
        wave(20, 10, 6);

        // enable dropped for 5 cycles mid-stream
        fork
            wave(20, 10, 4);
            begin
                repeat (25) @(negedge clk_in);
                enable = 1'b0;
                repeat (5) @(negedge clk_in);
                enable = 1'b1;
            end
        join

        // reset pulsed mid-period
        fork
            wave(20, 10, 4);
            begin
                repeat (33) @(negedge clk_in);
                reset = 1'b1;
                @(negedge clk_in);
                reset = 1'b0;
            end
        join

        // signal lost low, then recovers
        drive(1'b0, 150);
        wave(20, 10, 3);

        // period exactly at the timeout boundary, then one cycle beyond it
        wave(100, 30, 4);
        wave(101, 30, 3);

        // single-cycle glitch inside a 20-cycle period
        repeat (3) begin
            drive(1'b1, 10);
            drive(1'b0, 4);
            drive(1'b1, 1);
            drive(1'b0, 5);
        end
        wave(20, 10, 3);

        // stuck high after a rise
        drive(1'b1, 250);
        wave(20, 10, 3);

        // randomized periods, duty cycles, enable drops and resets
        for (int i = 0; i < 60; i++) begin
            p = int'($urandom_range(2, 130));
            h = int'($urandom_range(1, p - 1));
            n = int'($urandom_range(1, 3));
            wave(p, h, n);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk_in);
                enable = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk_in);
                enable = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk_in);
                reset = 1'b1;
                @(negedge clk_in);
                reset = 1'b0;
            end
        end

        drive(1'b0, 8);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
